// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - instruction fields in, datapath controls out, for the multi-cycle control FSM
interface multicycle_ctrl_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [2:0]         alu_control;
  logic               reg_write;
  logic               halted;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, halted, state_o
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, halted, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - Moore control FSM sequencing the shared multi-cycle RV32I datapath
module multicycle_ctrl_fsm #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int STATE_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       halted;
    logic       pc_update;
    logic       branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;

  // State-only outputs, decoded from the state being entered so they register alongside it.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_HALT:     c.halted = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      S_RST:      nxt = S_FETCH;
      S_FETCH:    nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXECUTER;
          OP_ITYPE:          nxt = S_EXECUTEI;
          OP_BEQ:            nxt = S_BEQ;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_RST;
    endcase
  end

  // Async clear of the registered strobes kills any in-flight mem_write/reg_write at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
      ctrl  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
    end
  end

  always_comb begin
    bus.imm_src = 2'b00;
    if (state != S_RST) begin
      case (bus.op)
        OP_STORE: bus.imm_src = 2'b01;
        OP_BEQ:   bus.imm_src = 2'b10;
        OP_JAL:   bus.imm_src = 2'b11;
        default:  bus.imm_src = 2'b00;
      endcase
    end
  end

  always_comb begin
    bus.alu_control = 3'b000;
    case (ctrl.alu_op)
      ALUOP_SUB: bus.alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
      default:   bus.alu_control = 3'b000;
    endcase
  end

  assign bus.pc_write   = ctrl.pc_update | (ctrl.branch & bus.zero);
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.result_src = ctrl.result_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.halted     = ctrl.halted;
  assign bus.state_o    = STATE_W'(state);

endmodule
